// File: rtl/mem2axi_master_if.sv
// AXI4 bus bundle (AW, W, B, AR, R) shared by mem2axi_master and its slave.
// The master modport drives requests and response readies; the slave modport is the mirror image.
interface mem2axi_master_if #(
  parameter int unsigned AXI_ID_WIDTH   = 5,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_USER_WIDTH = 64
);
  localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [5:0]                aw_atop;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0]     w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/mem2axi_master.sv
// Single-outstanding AXI4 master: turns a req/gnt memory port into single-beat
// AXI reads and writes, reporting each completion with a one-cycle rvalid_o pulse.
module mem2axi_master #(
  parameter int unsigned AXI_ID_WIDTH   = 5,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_USER_WIDTH = 64,
  parameter logic [AXI_ID_WIDTH-1:0] AXI_ID = '0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_i,
  output logic                        gnt_o,
  input  logic                        we_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
  input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
  output logic                        rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
  output logic                        err_o,
  mem2axi_master_if.master            master
);
  localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA} state_e;

  state_e                    state_q, state_d;
  logic                      aw_valid_q, aw_valid_d;
  logic                      w_valid_q, w_valid_d;
  logic                      ar_valid_q, ar_valid_d;
  logic                      b_ready_q, b_ready_d;
  logic                      r_ready_q, r_ready_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic                      rvalid_q, rvalid_d;
  logic                      err_q, err_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [STRB_WIDTH-1:0]     be_q, be_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = aw_valid_q & master.aw_ready;
  assign w_hs  = w_valid_q & master.w_ready;
  assign b_hs  = b_ready_q & master.b_valid;
  assign ar_hs = ar_valid_q & master.ar_ready;
  assign r_hs  = r_ready_q & master.r_valid;

  // Next-state and registered-output logic; gnt_o is the only combinational output.
  always_comb begin
    state_d    = state_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    ar_valid_d = ar_valid_q;
    b_ready_d  = b_ready_q;
    r_ready_d  = r_ready_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    err_d      = 1'b0;
    gnt_o      = 1'b0;

    case (state_q)
      IDLE: begin
        gnt_o = req_i;
        if (req_i) begin
          addr_d  = addr_i;
          be_d    = be_i;
          wdata_d = wdata_i;
          if (we_i) begin
            state_d    = WR;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            aw_done_d  = 1'b0;
            w_done_d   = 1'b0;
          end else begin
            state_d    = RD_ADDR;
            ar_valid_d = 1'b1;
          end
        end
      end
      // AW and W complete independently, in either order or together.
      WR: begin
        if (aw_hs) begin
          aw_valid_d = 1'b0;
          aw_done_d  = 1'b1;
        end
        if (w_hs) begin
          w_valid_d = 1'b0;
          w_done_d  = 1'b1;
        end
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
          state_d   = WR_RESP;
          b_ready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          state_d   = IDLE;
          b_ready_d = 1'b0;
          rvalid_d  = 1'b1;
          err_d     = master.b_resp[1];
        end
      end
      RD_ADDR: begin
        if (ar_hs) begin
          state_d    = RD_DATA;
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
        end
      end
      RD_DATA: begin
        if (r_hs) begin
          state_d   = IDLE;
          r_ready_d = 1'b0;
          rvalid_d  = 1'b1;
          err_d     = master.r_resp[1];
          rdata_d   = master.r_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      b_ready_q  <= 1'b0;
      r_ready_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      ar_valid_q <= ar_valid_d;
      b_ready_q  <= b_ready_d;
      r_ready_q  <= r_ready_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  // Fixed single-beat, 8-byte INCR attributes on both address channels.
  assign master.aw_id     = AXI_ID;
  assign master.aw_addr   = addr_q;
  assign master.aw_len    = 8'd0;
  assign master.aw_size   = 3'd3;
  assign master.aw_burst  = 2'b01;
  assign master.aw_lock   = 1'b0;
  assign master.aw_cache  = 4'd0;
  assign master.aw_prot   = 3'd0;
  assign master.aw_qos    = 4'd0;
  assign master.aw_region = 4'd0;
  assign master.aw_atop   = 6'd0;
  assign master.aw_user   = {AXI_USER_WIDTH{1'b0}};
  assign master.aw_valid  = aw_valid_q;

  assign master.w_data    = wdata_q;
  assign master.w_strb    = be_q;
  assign master.w_last    = 1'b1;
  assign master.w_user    = {AXI_USER_WIDTH{1'b0}};
  assign master.w_valid   = w_valid_q;

  assign master.b_ready   = b_ready_q;

  assign master.ar_id     = AXI_ID;
  assign master.ar_addr   = addr_q;
  assign master.ar_len    = 8'd0;
  assign master.ar_size   = 3'd3;
  assign master.ar_burst  = 2'b01;
  assign master.ar_lock   = 1'b0;
  assign master.ar_cache  = 4'd0;
  assign master.ar_prot   = 3'd0;
  assign master.ar_qos    = 4'd0;
  assign master.ar_region = 4'd0;
  assign master.ar_user   = {AXI_USER_WIDTH{1'b0}};
  assign master.ar_valid  = ar_valid_q;

  assign master.r_ready   = r_ready_q;

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

  // Response IDs, user bits and r_last carry no information for single-beat, single-ID traffic.
  logic unused_resp;
  assign unused_resp = ^{master.b_id, master.b_user, master.b_resp[0],
                         master.r_id, master.r_user, master.r_resp[0], master.r_last};
endmodule
